// File: rtl/proto_pkg.sv
// Shared constants and types for the protocol transaction scheduler.
package proto_pkg;

    localparam int TOKEN_W = 19;
    localparam int DOUT_W  = 72;
    localparam int DIN_W   = 64;

    localparam logic [1:0] TRANS_NON = 2'b00;
    localparam logic [1:0] TRANS_IN  = 2'b01;
    localparam logic [1:0] TRANS_OUT = 2'b10;

    typedef enum logic [1:0] {
        ST_OK           = 2'b00,
        ST_FAIL_NAK     = 2'b01,
        ST_FAIL_TIMEOUT = 2'b10,
        ST_FAIL_ILLEGAL = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        GAP   = 3'd3,
        RESP  = 3'd4
    } sched_state_e;

    function automatic logic trans_legal(input logic [1:0] code);
        return (code == TRANS_IN) || (code == TRANS_OUT);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the requester not just granted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr_q;

    always_comb begin
        gnt = 2'b00;
        if (ptr_q) begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end else begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (advance && (|gnt)) begin
            ptr_q <= gnt[0];
        end
    end

endmodule

// File: rtl/proto_sched.sv
// Shares one protocol engine between the rw and bulk engines with retry and watchdog.
// Optional statistics counters: define PROTO_SCHED_STATS_EN.
//
// state | meaning
// IDLE  | sample req, grant and latch the transaction
// ISSUE | present transaction with data_to_proto_avail for one cycle
// WAIT  | hold transaction, capture IN data, await pkt_done or watchdog
// GAP   | TRANS_NON between a failed attempt and the reissue
// RESP  | one-cycle ack with status to the granted requester
module proto_sched
    import proto_pkg::*;
#(
    parameter int unsigned MAX_ATTEMPTS = 3,
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned WDOG_CYCLES  = 4095
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  req,
    input  logic [1:0][1:0]             req_trans,
    input  logic [1:0][TOKEN_W-1:0]     req_token,
    input  logic [1:0][DOUT_W-1:0]      req_data,
    output logic [1:0]                  ack,
    output logic [1:0]                  ack_status,
    output logic [DIN_W-1:0]            rd_data,
    output logic [1:0]                  transaction,
    output logic [TOKEN_W-1:0]          token_to_proto,
    output logic [DOUT_W-1:0]           data_to_proto,
    output logic                        data_to_proto_avail,
    input  logic                        pkt_done,
    input  logic                        pkt_succeeded,
    input  logic [DIN_W-1:0]            data_from_proto,
    input  logic                        data_from_proto_avail,
    output logic [15:0]                 stat_ok,
    output logic [15:0]                 stat_fail,
    output logic [15:0]                 stat_retry
);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_ISSUE = ISSUE;
    localparam logic [2:0] S_WAIT  = WAIT;
    localparam logic [2:0] S_GAP   = GAP;
    localparam logic [2:0] S_RESP  = RESP;

    localparam logic [3:0]  MAX_A   = 4'(MAX_ATTEMPTS);
    localparam logic [7:0]  GAP_TC  = 8'(GAP_CYCLES - 1);
    localparam logic [11:0] WDOG_TC = 12'(WDOG_CYCLES);

    logic [2:0]  state_q;
    logic        gnt_idx_q;
    logic [1:0]  trans_q;
    logic [3:0]  attempt_q;
    logic [11:0] wdog_q;
    logic [7:0]  gap_q;

    logic [1:0]  arb_gnt;
    logic        arb_advance;
    logic        gnt_sel;
    logic [3:0]  attempt_inc;
    logic [11:0] wdog_inc;
    logic        wdog_expired;
    logic [1:0]  ack_onehot;

    assign arb_advance  = (state_q == S_IDLE);
    assign gnt_sel      = arb_gnt[1];
    assign attempt_inc  = attempt_q + 4'd1;
    assign wdog_inc     = wdog_q + 12'd1;
    assign wdog_expired = (wdog_inc == WDOG_TC);
    assign ack_onehot   = gnt_idx_q ? 2'b10 : 2'b01;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (arb_advance),
        .gnt     (arb_gnt)
    );

    // Outputs are driven from the transition into each state so they are registered.
    // The watchdog counts from the issue cycle, so it expires WDOG_CYCLES after ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= S_IDLE;
            gnt_idx_q           <= 1'b0;
            trans_q             <= TRANS_NON;
            attempt_q           <= 4'd0;
            wdog_q              <= 12'd0;
            gap_q               <= 8'd0;
            ack                 <= 2'b00;
            ack_status          <= ST_OK;
            rd_data             <= '0;
            transaction         <= TRANS_NON;
            token_to_proto      <= '0;
            data_to_proto       <= '0;
            data_to_proto_avail <= 1'b0;
        end else begin
            ack <= 2'b00;
            case (state_q)
                S_IDLE: begin
                    if (|arb_gnt) begin
                        gnt_idx_q      <= gnt_sel;
                        trans_q        <= req_trans[gnt_sel];
                        token_to_proto <= req_token[gnt_sel];
                        data_to_proto  <= req_data[gnt_sel];
                        attempt_q      <= 4'd0;
                        wdog_q         <= 12'd0;
                        if (trans_legal(req_trans[gnt_sel])) begin
                            state_q             <= S_ISSUE;
                            transaction         <= req_trans[gnt_sel];
                            data_to_proto_avail <= 1'b1;
                        end else begin
                            state_q    <= S_RESP;
                            ack        <= arb_gnt;
                            ack_status <= ST_FAIL_ILLEGAL;
                        end
                    end
                end
                S_ISSUE: begin
                    data_to_proto_avail <= 1'b0;
                    wdog_q              <= wdog_inc;
                    state_q             <= S_WAIT;
                end
                S_WAIT: begin
                    wdog_q <= wdog_inc;
                    if ((trans_q == TRANS_IN) && data_from_proto_avail) begin
                        rd_data <= data_from_proto;
                    end
                    if (pkt_done) begin
                        if (pkt_succeeded) begin
                            state_q     <= S_RESP;
                            transaction <= TRANS_NON;
                            ack         <= ack_onehot;
                            ack_status  <= ST_OK;
                        end else begin
                            attempt_q <= attempt_inc;
                            if (attempt_inc < MAX_A) begin
                                state_q     <= S_GAP;
                                transaction <= TRANS_NON;
                                wdog_q      <= 12'd0;
                                gap_q       <= GAP_TC;
                            end else begin
                                state_q     <= S_RESP;
                                transaction <= TRANS_NON;
                                ack         <= ack_onehot;
                                ack_status  <= ST_FAIL_NAK;
                            end
                        end
                    end else if (wdog_expired) begin
                        state_q     <= S_RESP;
                        transaction <= TRANS_NON;
                        ack         <= ack_onehot;
                        ack_status  <= ST_FAIL_TIMEOUT;
                    end
                end
                S_GAP: begin
                    if (gap_q == 8'd0) begin
                        state_q             <= S_ISSUE;
                        transaction         <= trans_q;
                        data_to_proto_avail <= 1'b1;
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q             <= S_IDLE;
                    transaction         <= TRANS_NON;
                    data_to_proto_avail <= 1'b0;
                end
            endcase
        end
    end

`ifdef PROTO_SCHED_STATS_EN
    logic [15:0] ok_q;
    logic [15:0] fail_q;
    logic [15:0] retry_q;
    logic        retry_go;

    assign retry_go = (state_q == S_WAIT) && pkt_done && !pkt_succeeded
                      && (attempt_inc < MAX_A);

    always_ff @(posedge clk) begin
        if (rst) begin
            ok_q    <= 16'd0;
            fail_q  <= 16'd0;
            retry_q <= 16'd0;
        end else begin
            if ((|ack) && (ack_status == ST_OK) && (ok_q != 16'hFFFF)) begin
                ok_q <= ok_q + 16'd1;
            end
            if ((|ack) && (ack_status != ST_OK) && (fail_q != 16'hFFFF)) begin
                fail_q <= fail_q + 16'd1;
            end
            if (retry_go && (retry_q != 16'hFFFF)) begin
                retry_q <= retry_q + 16'd1;
            end
        end
    end

    assign stat_ok    = ok_q;
    assign stat_fail  = fail_q;
    assign stat_retry = retry_q;
`else
    assign stat_ok    = 16'd0;
    assign stat_fail  = 16'd0;
    assign stat_retry = 16'd0;
`endif

endmodule
